// File: rtl/mod6_seq_checker.sv
// mod6_seq_checker: watches the samples of a free-running mod-6 counter,
// locks once LOCK_CNT consecutive samples follow the 0..5 wrap sequence,
// and flags and counts every fault (illegal value or loss of sequence).
module mod6_seq_checker #(
    parameter int unsigned LOCK_CNT = 3   // legal range 2..7
) (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active low
    input  logic       valid,
    input  logic [2:0] count_in,
    input  logic       clr_err,
    output logic       locked,
    output logic       error,
    output logic [7:0] err_count,
    output logic [2:0] expected
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_VAL = 3'(LOCK_CNT);
    localparam logic [7:0] ERR_MAX  = 8'd255;

    // Successor of a legal mod-6 value (5 wraps to 0).
    function automatic logic [2:0] next_val(input logic [2:0] v);
        return (v == 3'd5) ? 3'd0 : v + 3'd1;
    endfunction

    state_t     r_state,     w_state_nxt;
    logic [2:0] r_match,     w_match_nxt;
    logic [2:0] r_expected,  w_expected_nxt;
    logic       r_locked,    w_locked_nxt;
    logic       r_error;
    logic [7:0] r_err_count, w_err_count_nxt;

    logic       w_fault;
    logic       w_legal;
    logic       w_hit;
    logic [2:0] w_match_inc;

    assign w_legal     = (count_in <= 3'd5);
    assign w_hit       = (count_in == r_expected);
    assign w_match_inc = r_match + 3'd1;

    // Next-state and next-output decode for one sample.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case statement can leave it unassigned (no latches).
        w_state_nxt    = r_state;
        w_match_nxt    = r_match;
        w_expected_nxt = r_expected;
        w_locked_nxt   = r_locked;
        w_fault        = 1'b0;

        if (valid) begin
            unique case (r_state)
                ST_HUNT: begin
                    if (w_legal) begin
                        // LOCK_CNT >= 2, so one sample can never lock.
                        w_expected_nxt = next_val(count_in);
                        w_match_nxt    = 3'd1;
                        w_state_nxt    = ST_SYNC;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (!w_legal) begin
                        w_fault     = 1'b1;
                        w_match_nxt = 3'd0;
                        w_state_nxt = ST_HUNT;
                    end else if (w_hit) begin
                        w_match_nxt    = w_match_inc;
                        w_expected_nxt = next_val(count_in);
                        if (w_match_inc == LOCK_VAL) begin
                            w_state_nxt  = ST_LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        // Legal but out of sequence: restart the run here.
                        w_match_nxt    = 3'd1;
                        w_expected_nxt = next_val(count_in);
                    end
                end
                ST_LOCKED: begin
                    if (w_hit) begin
                        w_expected_nxt = next_val(count_in);
                    end else begin
                        // Lost lock: expected is left as the missed value.
                        w_fault      = 1'b1;
                        w_match_nxt  = 3'd0;
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = ST_HUNT;
                    end
                end
                default: begin
                    w_match_nxt  = 3'd0;
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_HUNT;
                end
            endcase
        end
    end

    // Fault counter: clear wins over a coincident increment; saturates at 255.
    always_comb begin
        w_err_count_nxt = r_err_count;
        if (clr_err) begin
            w_err_count_nxt = 8'd0;
        end else if (w_fault && (r_err_count != ERR_MAX)) begin
            w_err_count_nxt = r_err_count + 8'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_match     <= 3'd0;
            r_expected  <= 3'd0;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            r_state     <= w_state_nxt;
            r_match     <= w_match_nxt;
            r_expected  <= w_expected_nxt;
            r_locked    <= w_locked_nxt;
            r_error     <= w_fault;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked    = r_locked;
    assign error     = r_error;
    assign err_count = r_err_count;
    assign expected  = r_expected;

endmodule

// File: tb/tb_mod6_seq_checker.sv
// Directed bench for mod6_seq_checker with hand-computed expectations.
`timescale 1ns/1ps
module tb_mod6_seq_checker;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [2:0] count_in;
    logic       clr_err;
    logic       locked;
    logic       error;
    logic [7:0] err_count;
    logic [2:0] expected;

    int n_total = 0;
    int n_bad   = 0;

    mod6_seq_checker #(.LOCK_CNT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .count_in  (count_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .error     (error),
        .err_count (err_count),
        .expected  (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one valid sample, let the edge take it, settle #1 after the edge.
    task automatic sample(input logic [2:0] v);
        valid    = 1'b1;
        count_in = v;
        @(posedge clk);
        #1;
        valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset pulse spanning a couple of edges, released away from any edge.
    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    initial begin
        reset    = 1'b0;
        valid    = 1'b0;
        count_in = 3'd0;
        clr_err  = 1'b0;
        idle(2);
        check("rst_locked", 32'(locked), 0);
        check("rst_error",  32'(error), 0);
        check("rst_errcnt", 32'(err_count), 0);
        check("rst_expect", 32'(expected), 0);
        reset = 1'b1;
        idle(1);

        // Clean 0..5,0 sequence: lock after the third sample.
        sample(3'd0);
        check("seq0_locked", 32'(locked), 0);
        check("seq0_expect", 32'(expected), 1);
        sample(3'd1);
        check("seq1_locked", 32'(locked), 0);
        sample(3'd2);
        check("seq2_locked", 32'(locked), 1);
        check("seq2_expect", 32'(expected), 3);
        sample(3'd3);
        sample(3'd4);
        sample(3'd5);
        sample(3'd0);
        check("seq_end_expect", 32'(expected), 1);
        check("seq_end_locked", 32'(locked), 1);
        check("seq_end_error",  32'(error), 0);
        check("seq_end_errcnt", 32'(err_count), 0);

        // Hold with valid low.
        idle(2);
        check("hold_expect", 32'(expected), 1);
        check("hold_locked", 32'(locked), 1);

        // Locked, feed 3 where 4 is expected.
        sample(3'd1);
        sample(3'd2);
        sample(3'd3);
        check("pre_miss_expect", 32'(expected), 4);
        sample(3'd3);
        check("miss_error",  32'(error), 1);
        check("miss_errcnt", 32'(err_count), 1);
        check("miss_locked", 32'(locked), 0);
        check("miss_expect", 32'(expected), 4);
        idle(1);
        check("miss_pulse_once", 32'(error), 0);
        sample(3'd4);
        check("relock4_error", 32'(error), 0);
        sample(3'd5);
        check("relock5_locked", 32'(locked), 0);
        sample(3'd0);
        check("relock0_locked", 32'(locked), 1);
        check("relock0_error",  32'(error), 0);
        check("relock0_errcnt", 32'(err_count), 1);

        // Illegal values in HUNT and SYNC.
        do_reset();
        sample(3'd7);
        check("hunt7_error",  32'(error), 1);
        check("hunt7_errcnt", 32'(err_count), 1);
        sample(3'd2);
        check("hunt2_error", 32'(error), 0);
        sample(3'd3);
        sample(3'd6);
        check("sync6_error",  32'(error), 1);
        check("sync6_errcnt", 32'(err_count), 2);
        sample(3'd4);
        sample(3'd5);
        check("after6_not_locked", 32'(locked), 0);
        sample(3'd0);
        check("after6_locked", 32'(locked), 1);

        // Legal mismatch in SYNC restarts the run without a fault.
        do_reset();
        sample(3'd1);
        sample(3'd2);
        sample(3'd4);
        check("syncmis_error",  32'(error), 0);
        check("syncmis_expect", 32'(expected), 5);
        check("syncmis_locked", 32'(locked), 0);
        sample(3'd5);
        check("syncmis5_locked", 32'(locked), 0);
        sample(3'd0);
        check("syncmis0_locked", 32'(locked), 1);
        check("syncmis_errcnt",  32'(err_count), 0);

        // Saturation and clear priority.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sample(3'd7);
            if (i == 253) check("sat_254", 32'(err_count), 254);
            if (i == 254) check("sat_255", 32'(err_count), 255);
        end
        check("sat_final",  32'(err_count), 255);
        check("sat_error",  32'(error), 1);
        clr_err = 1'b1;
        sample(3'd6);
        clr_err = 1'b0;
        check("clr_errcnt", 32'(err_count), 0);
        check("clr_error",  32'(error), 1);
        sample(3'd7);
        check("post_clr_errcnt", 32'(err_count), 1);

        // Async reset while locked, then relock.
        do_reset();
        sample(3'd3);
        sample(3'd4);
        sample(3'd5);
        check("pre_async_locked", 32'(locked), 1);
        idle(5);
        check("idle_locked", 32'(locked), 1);
        check("idle_expect", 32'(expected), 0);
        check("idle_error",  32'(error), 0);
        sample(3'd0);
        sample(3'd7);
        check("pre_async_errcnt", 32'(err_count), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_locked", 32'(locked), 0);
        check("async_errcnt", 32'(err_count), 0);
        check("async_expect", 32'(expected), 0);
        check("async_error",  32'(error), 0);
        // Samples presented while reset is low are ignored.
        valid    = 1'b1;
        count_in = 3'd7;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        check("inrst_errcnt", 32'(err_count), 0);
        reset = 1'b1;
        idle(1);
        sample(3'd3);
        check("rl3_locked", 32'(locked), 0);
        check("rl3_expect", 32'(expected), 4);
        sample(3'd4);
        sample(3'd5);
        check("rl5_locked", 32'(locked), 1);
        check("rl5_error",  32'(error), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mod6_seq_checker.md
MOD6_SEQ_CHECKER -- requirements
Module: mod6_seq_checker

Interface
REQ-001 Parameter: LOCK_CNT, default 3, number of consecutive correct samples that SHALL be required to declare lock (legal range 2..7).
REQ-002 Port: clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; low SHALL force the reset state immediately, independent of clk.
REQ-004 Port: valid  input  1  sample strobe; count_in SHALL be evaluated only on edges where valid=1.
REQ-005 Port: count_in  input  3  observed mod-6 counter value; legal values 0..5.
REQ-006 Port: clr_err  input  1  synchronous clear of err_count.
REQ-007 Port: locked  output  1  high while the state is LOCKED.
REQ-008 Port: error  output  1  one-cycle pulse per detected fault.
REQ-009 Port: err_count  output  8  saturating fault count.
REQ-010 Port: expected  output  3  next value predicted for count_in.

Function
REQ-011 All outputs SHALL be registered; the response to a sample SHALL appear on the edge that samples valid=1 (visible one cycle after the sample is presented).
REQ-012 The block SHALL implement three states: HUNT, SYNC and LOCKED; an internal match counter SHALL be 3 bits wide.
REQ-013 next(v) SHALL be v+1 for v in 0..4, and next(5) SHALL be 0 (wrap-around).
REQ-014 With valid=0, state, expected, match counter, locked and err_count SHALL hold, and error SHALL be 0.
REQ-015 HUNT, legal sample: expected<=next(count_in), match<=1, state<=SYNC.
REQ-016 HUNT, illegal sample (6 or 7): stay in HUNT, pulse error, increment err_count.
REQ-017 SYNC, count_in==expected: match<=match+1, expected<=next(count_in); when match+1==LOCK_CNT, go to LOCKED.
REQ-018 SYNC, legal mismatch: stay in SYNC, match<=1, expected<=next(count_in), no error.
REQ-019 SYNC, illegal sample: go to HUNT, pulse error, increment err_count.
REQ-020 LOCKED, count_in==expected: stay in LOCKED, expected<=next(count_in).
REQ-021 LOCKED, any mismatch (legal or illegal): pulse error, increment err_count, go to HUNT, locked<=0 on the same edge, expected holds.
REQ-022 err_count SHALL saturate at 255; a fault at 255 SHALL still pulse error.
REQ-023 clr_err=1 SHALL set err_count to 0 on that edge and take priority over a coincident increment; the coincident error pulse SHALL still assert.
REQ-024 error SHALL never be high for two consecutive cycles unless faulted samples arrive on consecutive valid cycles.

Reset
REQ-025 Reset low SHALL immediately force: state=HUNT, match=0, expected=0, locked=0, error=0, err_count=0.
REQ-026 Reset asserted mid-operation (SYNC or LOCKED) SHALL discard all progress; after release, the first valid sample SHALL be treated as in HUNT.
REQ-027 Reset release SHALL take effect synchronously on the first rising clk edge after reset rises; no sample SHALL be evaluated while reset is low.

Verification
REQ-028 Reset low, then valid each cycle with 0,1,2,3,4,5,0: locked rises after the third sample (count_in=2), expected=1 after the final 0, and error stays 0.
REQ-029 Once locked, feed 3 where 4 is expected: error pulses once, err_count=1, locked=0 on the same edge; then 4,5,0 relocks with no further error.
REQ-030 In HUNT, feed 7: error pulses and err_count=1; in SYNC after 2,3, feed 6: state returns to HUNT and err_count=2.
REQ-031 In SYNC after 1,2, feed 4: no error, match=1, expected=5; then 5,0 gives locked=1.
REQ-032 Force 300 faults: err_count=255 and error still pulses; clr_err coincident with a fault gives err_count=0 with error=1.
REQ-033 While locked, drop valid for 5 cycles, then pull reset low mid-cycle: outputs clear immediately without a clock edge; after release, the sequence 3,4,5 relocks.
